// File: rtl/wbn2apb_dec_if.sv
// wbn2apb_dec_if: Wishbone classic slave side and APB4 master side of the bridge
interface wbn2apb_dec_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int NS = 4
);
   localparam int SW = DW / 8;
   logic             wbn_cyc;
   logic             wbn_we;
   logic             wbn_stb;
   logic [AW-1:0]    wbn_adr;
   logic [SW-1:0]    wbn_sel;
   logic [DW-1:0]    wbn_dat_w;
   logic [DW-1:0]    wbn_dat_r;
   logic             wbn_ack;
   logic             wbn_err;
   logic             wbn_rty;
   logic [NS-1:0]    apb_psel;
   logic             apb_penable;
   logic             apb_pwrite;
   logic [SW-1:0]    apb_pstrb;
   logic [AW-1:0]    apb_paddr;
   logic [DW-1:0]    apb_pwdata;
   logic [NS*DW-1:0] apb_prdata;
   logic [NS-1:0]    apb_pready;
   logic [NS-1:0]    apb_pslverr;
   modport slave (
      input  wbn_cyc, wbn_we, wbn_stb, wbn_adr, wbn_sel, wbn_dat_w,
      output wbn_dat_r, wbn_ack, wbn_err, wbn_rty,
      output apb_psel, apb_penable, apb_pwrite, apb_pstrb, apb_paddr, apb_pwdata,
      input  apb_prdata, apb_pready, apb_pslverr
   );
   modport master (
      output wbn_cyc, wbn_we, wbn_stb, wbn_adr, wbn_sel, wbn_dat_w,
      input  wbn_dat_r, wbn_ack, wbn_err, wbn_rty,
      input  apb_psel, apb_penable, apb_pwrite, apb_pstrb, apb_paddr, apb_pwdata,
      output apb_prdata, apb_pready, apb_pslverr
   );
endinterface

// File: rtl/wbn2apb_dec.sv
// wbn2apb_dec: Wishbone classic slave to APB4 master bridge with NS-way decode and wait timeout
module wbn2apb_dec #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NS      = 4,
   parameter int DEC_LSB = 12,
   parameter int TMO     = 16
) (
   input logic          clk,
   input logic          rst,
   wbn2apb_dec_if.slave bus
);
   localparam int SW = DW / 8;
   localparam int IW = NS > 1 ? $clog2(NS) : 1;
   localparam int CW = TMO > 0 ? $clog2(TMO + 1) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] adr_q, adr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdat_q, wdat_d;
   logic [DW-1:0] dat_r_q, dat_r_d;
   logic [SW-1:0] strb_q, strb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          berr_q, berr_d;
   logic          abort_q, abort_d;
   logic [NS-1:0] oh;
   logic [DW-1:0] rdata;
   logic          rdy, slverr, req, valid, abort_now, tmo_hit;
   logic [IW-1:0] req_idx;
   // one-hot select of the latched slave and mux of its read data
   always_comb begin
      oh = '0;
      rdata = '0;
      for (int i = 0; i < NS; i++) begin
         oh[i] = idx_q == IW'(i);
         if (oh[i]) rdata = bus.apb_prdata[i*DW +: DW];
      end
   end
   assign rdy       = |(oh & bus.apb_pready);
   assign slverr    = |(oh & bus.apb_pslverr);
   assign req       = bus.wbn_cyc & bus.wbn_stb;
   assign req_idx   = bus.wbn_adr[DEC_LSB +: IW];
   assign valid     = 32'(req_idx) < NS;
   assign abort_now = abort_q | ~bus.wbn_cyc;
   assign tmo_hit   = (TMO > 0) && (32'(cnt_q) + 32'd1 >= 32'(TMO));
   // next state: decode in IDLE, APB handshake, timeout and abort bookkeeping
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      adr_d   = adr_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      dat_r_d = dat_r_q;
      strb_d  = strb_q;
      cnt_d   = cnt_q;
      berr_d  = berr_q;
      abort_d = abort_q;
      case (state_q)
         IDLE: if (req) begin
            idx_d   = req_idx;
            adr_d   = bus.wbn_adr;
            we_d    = bus.wbn_we;
            wdat_d  = bus.wbn_dat_w;
            strb_d  = bus.wbn_we ? bus.wbn_sel : '0;
            cnt_d   = '0;
            abort_d = 1'b0;
            berr_d  = ~valid;
            state_d = valid ? SETUP : RESP;
         end
         SETUP: begin
            cnt_d   = '0;
            abort_d = abort_now;
            state_d = ACCESS;
         end
         ACCESS: begin
            abort_d = abort_now;
            if (rdy) begin
               berr_d  = slverr;
               dat_r_d = we_q ? dat_r_q : rdata;
               state_d = abort_now ? IDLE : RESP;
            end else if (tmo_hit) begin
               berr_d  = 1'b1;
               state_d = abort_now ? IDLE : RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state register with synchronous reset clearing every output source
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         dat_r_q <= '0;
         strb_q  <= '0;
         cnt_q   <= '0;
         berr_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         dat_r_q <= dat_r_d;
         strb_q  <= strb_d;
         cnt_q   <= cnt_d;
         berr_q  <= berr_d;
         abort_q <= abort_d;
      end
   end
   assign bus.apb_psel    = (state_q == SETUP || state_q == ACCESS) ? oh : '0;
   assign bus.apb_penable = state_q == ACCESS;
   assign bus.apb_pwrite  = we_q;
   assign bus.apb_pstrb   = strb_q;
   assign bus.apb_paddr   = adr_q;
   assign bus.apb_pwdata  = wdat_q;
   assign bus.wbn_dat_r   = dat_r_q;
   assign bus.wbn_ack     = state_q == RESP && !berr_q;
   assign bus.wbn_err     = state_q == RESP && berr_q;
   assign bus.wbn_rty     = 1'b0;
endmodule
